// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: cache lookup first, otherwise four byte reads
// through the memory arbiter, little-endian assembly and cache refill.
module if_fetch_ctrl #(
   parameter int unsigned            ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0]  CACHE_LIMIT = ADDR_WIDTH'(32'h0004_0000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_pc,
   input  logic                  fetch_flush,
   output logic                  fetch_busy,
   output logic                  fetch_done,
   output logic [31:0]           fetch_inst,
   output logic                  cache_query,
   output logic [ADDR_WIDTH-1:0] query_addr,
   input  logic                  inst_hit_i,
   input  logic [31:0]           inst_cache_i,
   output logic                  cache_enable,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   output logic [31:0]           cache_wdata,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic [7:0]            mem_din
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned RX_W   = 2;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned PART_W = 24;
   localparam logic [CNT_W-1:0] NUM_BYTES = CNT_W'(4);

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]      issue_cnt, issue_d;
   logic [RX_W-1:0]       rx_cnt, rx_cnt_d;
   logic                  rx_pend, rx_pend_d;
   logic [PART_W-1:0]     word_q, word_d;
   logic                  cacheable_q, cacheable_d;
   logic                  done_d;
   logic [WORD_W-1:0]     inst_d;
   logic                  cen_d;
   logic [ADDR_WIDTH-1:0] caddr_d;
   logic [WORD_W-1:0]     cwdata_d;

   logic                  pc_cacheable;
   logic                  issue;
   logic [WORD_W-1:0]     full_word;

   // Combinational strobes; gated by rst so they drop the instant reset asserts.
   assign pc_cacheable = fetch_pc < CACHE_LIMIT;
   assign fetch_busy   = (state != IDLE);
   assign cache_query  = rst && (state == IDLE) && fetch_req && !fetch_flush && pc_cacheable;
   assign query_addr   = fetch_pc;
   assign mem_req      = rst && (state == FILL) && (issue_cnt < NUM_BYTES);
   assign mem_addr     = pc_q + ADDR_WIDTH'(issue_cnt);
   assign issue        = mem_req && mem_gnt;
   assign full_word    = {mem_din, word_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pc_q         <= '0;
         issue_cnt    <= '0;
         rx_cnt       <= '0;
         rx_pend      <= 1'b0;
         word_q       <= '0;
         cacheable_q  <= 1'b0;
         fetch_done   <= 1'b0;
         fetch_inst   <= '0;
         cache_enable <= 1'b0;
         cache_addr   <= '0;
         cache_wdata  <= '0;
      end else begin
         state        <= state_d;
         pc_q         <= pc_d;
         issue_cnt    <= issue_d;
         rx_cnt       <= rx_cnt_d;
         rx_pend      <= rx_pend_d;
         word_q       <= word_d;
         cacheable_q  <= cacheable_d;
         fetch_done   <= done_d;
         fetch_inst   <= inst_d;
         cache_enable <= cen_d;
         cache_addr   <= caddr_d;
         cache_wdata  <= cwdata_d;
      end
   end

   always_comb begin
      state_d     = state;
      pc_d        = pc_q;
      issue_d     = issue_cnt;
      rx_cnt_d    = rx_cnt;
      rx_pend_d   = 1'b0;
      word_d      = word_q;
      cacheable_d = cacheable_q;
      done_d      = 1'b0;
      inst_d      = fetch_inst;
      cen_d       = 1'b0;
      caddr_d     = cache_addr;
      cwdata_d    = cache_wdata;

      case (state)
         IDLE: begin
            if (fetch_req && !fetch_flush) begin
               if (cache_query && inst_hit_i) begin
                  done_d = 1'b1;
                  inst_d = inst_cache_i;
               end else begin
                  state_d     = FILL;
                  pc_d        = fetch_pc;
                  issue_d     = '0;
                  rx_cnt_d    = '0;
                  cacheable_d = pc_cacheable;
               end
            end
         end
         FILL: begin
            if (fetch_flush) begin
               // Abandon the fetch; any byte still in flight is dropped.
               state_d  = IDLE;
               issue_d  = '0;
               rx_cnt_d = '0;
            end else begin
               if (issue) begin
                  issue_d   = issue_cnt + CNT_W'(1);
                  rx_pend_d = 1'b1;
               end
               if (rx_pend) begin
                  rx_cnt_d = rx_cnt + RX_W'(1);
                  case (rx_cnt)
                     2'd0: word_d[7:0]   = mem_din;
                     2'd1: word_d[15:8]  = mem_din;
                     2'd2: word_d[23:16] = mem_din;
                     default: begin
                        done_d   = 1'b1;
                        inst_d   = full_word;
                        state_d  = IDLE;
                        issue_d  = '0;
                        rx_cnt_d = '0;
                        if (cacheable_q) begin
                           cen_d    = 1'b1;
                           caddr_d  = pc_q;
                           cwdata_d = full_word;
                        end
                     end
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: byte-memory responder plus a queue
// of expected instruction words popped whenever fetch_done pulses.
module tb_if_fetch_ctrl;

   localparam logic [31:0] LIMIT = 32'h0004_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_flush;
   logic        fetch_busy;
   logic        fetch_done;
   logic [31:0] fetch_inst;
   logic        cache_query;
   logic [31:0] query_addr;
   logic        inst_hit_i;
   logic [31:0] inst_cache_i;
   logic        cache_enable;
   logic [31:0] cache_addr;
   logic [31:0] cache_wdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic [7:0]  mem_din;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]  mem [logic [31:0]];
   logic [31:0] exp_q [$];

   if_fetch_ctrl #(.ADDR_WIDTH(32), .CACHE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_flush(fetch_flush),
      .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_inst(fetch_inst),
      .cache_query(cache_query), .query_addr(query_addr),
      .inst_hit_i(inst_hit_i), .inst_cache_i(inst_cache_i),
      .cache_enable(cache_enable), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_din(mem_din)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
   endfunction

   // Byte memory: data appears the cycle after an issuing edge, junk otherwise.
   always @(posedge clk) begin
      logic [31:0] a;
      if (rst && mem_req && mem_gnt) begin
         a = mem_addr;
         #1 mem_din = mem_rd(a);
      end else begin
         #1 mem_din = 8'hEE;
      end
   end

   task automatic test_reset();
      rst = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h100; fetch_flush = 1'b0;
      inst_hit_i = 1'b0; inst_cache_i = 32'h0; mem_gnt = 1'b1;
      #12;
      tests_run += 8;
      if (fetch_busy !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", fetch_busy); end
      if (mem_req !== 1'b0)     begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
      if (cache_query !== 1'b0) begin tests_failed++; $display("FAIL reset_query: got %b expected 0", cache_query); end
      if (fetch_done !== 1'b0)  begin tests_failed++; $display("FAIL reset_done: got %b expected 0", fetch_done); end
      if (fetch_inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h expected 0", fetch_inst); end
      if (cache_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_cen: got %b expected 0", cache_enable); end
      if (cache_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_caddr: got %h expected 0", cache_addr); end
      if (cache_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_cwdata: got %h expected 0", cache_wdata); end
      @(negedge clk);
      rst = 1'b1; fetch_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hit(input logic [31:0] pc, input logic [31:0] data);
      logic [31:0] e;
      fetch_req = 1'b1; fetch_pc = pc; inst_hit_i = 1'b1; inst_cache_i = data;
      #1;
      tests_run += 3;
      if (cache_query !== 1'b1) begin tests_failed++; $display("FAIL hit_query: got %b expected 1", cache_query); end
      if (query_addr !== pc)    begin tests_failed++; $display("FAIL hit_qaddr: got %h expected %h", query_addr, pc); end
      if (mem_req !== 1'b0)     begin tests_failed++; $display("FAIL hit_mem_req: got %b expected 0", mem_req); end
      exp_q.push_back(data);
      @(negedge clk);
      tests_run += 3;
      if (fetch_done !== 1'b1) begin
         tests_failed++; $display("FAIL hit_done: got %b expected 1", fetch_done);
      end else begin
         e = exp_q.pop_front();
         if (fetch_inst !== e) begin tests_failed++; $display("FAIL hit_inst: got %h expected %h", fetch_inst, e); end
      end
      if (cache_enable !== 1'b0) begin tests_failed++; $display("FAIL hit_cen: got %b expected 0", cache_enable); end
      if (fetch_busy !== 1'b0)   begin tests_failed++; $display("FAIL hit_busy: got %b expected 0", fetch_busy); end
      fetch_req = 1'b0; inst_hit_i = 1'b0; inst_cache_i = 32'hFFFF_FFFF;
      @(negedge clk);
      tests_run += 2;
      if (fetch_done !== 1'b0) begin tests_failed++; $display("FAIL hit_pulse: got %b expected 0", fetch_done); end
      if (fetch_inst !== data) begin tests_failed++; $display("FAIL hit_hold: got %h expected %h", fetch_inst, data); end
   endtask

   // Miss or uncacheable fetch; grant dropped for stall_len cycles after the second issue.
   task automatic test_fill(input string name, input logic [31:0] pc, input int stall_len);
      logic        exp_c;
      logic [31:0] exp_w, e;
      int          issued, stalls, lat;
      bit          seen;
      exp_c = (pc < LIMIT);
      exp_w = mem_word(pc);
      fetch_req = 1'b1; fetch_pc = pc; inst_hit_i = 1'b0; inst_cache_i = 32'hBAD0_BAD0;
      mem_gnt = 1'b1;
      #1;
      tests_run++;
      if (cache_query !== exp_c) begin tests_failed++; $display("FAIL %s_query: got %b expected %b", name, cache_query, exp_c); end
      exp_q.push_back(exp_w);
      issued = 0; stalls = 0; seen = 0; lat = 5 + stall_len;
      for (int j = 0; j <= lat + 2 && !seen; j++) begin
         @(negedge clk);
         if (j == 0) begin fetch_req = 1'b0; fetch_pc = 32'hDEAD_BEE0; end
         if (fetch_done === 1'b1) begin
            seen = 1;
            e = exp_q.pop_front();
            tests_run += 4;
            if (j != lat) begin tests_failed++; $display("FAIL %s_latency: got %0d expected %0d", name, j, lat); end
            if (fetch_inst !== e) begin tests_failed++; $display("FAIL %s_inst: got %h expected %h", name, fetch_inst, e); end
            if (cache_enable !== exp_c) begin tests_failed++; $display("FAIL %s_cen: got %b expected %b", name, cache_enable, exp_c); end
            if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL %s_busy_end: got %b expected 0", name, fetch_busy); end
            if (exp_c) begin
               tests_run += 2;
               if (cache_addr !== pc)     begin tests_failed++; $display("FAIL %s_caddr: got %h expected %h", name, cache_addr, pc); end
               if (cache_wdata !== exp_w) begin tests_failed++; $display("FAIL %s_cwdata: got %h expected %h", name, cache_wdata, exp_w); end
            end
         end else begin
            tests_run += 2;
            if (cache_enable !== 1'b0) begin tests_failed++; $display("FAIL %s_cen_early: got %b expected 0 at cycle %0d", name, cache_enable, j); end
            if (fetch_busy !== 1'b1)   begin tests_failed++; $display("FAIL %s_busy: got %b expected 1 at cycle %0d", name, fetch_busy, j); end
            mem_gnt = !(issued == 2 && stalls < stall_len);
            if (!mem_gnt) stalls++;
            #1;
            if (issued < 4) begin
               tests_run++;
               if (mem_req !== 1'b1 || mem_addr !== pc + 32'(issued)) begin
                  tests_failed++;
                  $display("FAIL %s_mem_addr: got req=%b addr=%h expected req=1 addr=%h", name, mem_req, mem_addr, pc + 32'(issued));
               end
               if (mem_gnt) issued++;
            end
         end
      end
      if (!seen) begin
         tests_run++; tests_failed++;
         $display("FAIL %s_timeout: got no fetch_done expected one at cycle %0d", name, lat);
         void'(exp_q.pop_front());
      end
      mem_gnt = 1'b1;
   endtask

   task automatic test_flush();
      fetch_req = 1'b1; fetch_pc = 32'h300; inst_hit_i = 1'b0; mem_gnt = 1'b1;
      for (int j = 0; j <= 4; j++) begin
         @(negedge clk);
         if (j == 0) fetch_req = 1'b0;
         tests_run++;
         if (fetch_done !== 1'b0) begin tests_failed++; $display("FAIL flush_early_done: got %b expected 0", fetch_done); end
      end
      fetch_flush = 1'b1;
      @(negedge clk);
      fetch_flush = 1'b0;
      tests_run += 4;
      if (fetch_done !== 1'b0)   begin tests_failed++; $display("FAIL flush_done: got %b expected 0", fetch_done); end
      if (cache_enable !== 1'b0) begin tests_failed++; $display("FAIL flush_cen: got %b expected 0", cache_enable); end
      if (fetch_busy !== 1'b0)   begin tests_failed++; $display("FAIL flush_busy: got %b expected 0", fetch_busy); end
      if (mem_req !== 1'b0)      begin tests_failed++; $display("FAIL flush_mem_req: got %b expected 0", mem_req); end
      test_fill("after_flush", 32'h400, 0);
   endtask

   task automatic test_async_reset();
      fetch_req = 1'b1; fetch_pc = 32'h500; inst_hit_i = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      @(negedge clk);
      #2;
      fetch_req = 1'b1; fetch_pc = 32'h100;
      rst = 1'b0;
      #1;
      tests_run += 3;
      if (mem_req !== 1'b0)     begin tests_failed++; $display("FAIL areset_mem_req: got %b expected 0", mem_req); end
      if (fetch_busy !== 1'b0)  begin tests_failed++; $display("FAIL areset_busy: got %b expected 0", fetch_busy); end
      if (cache_query !== 1'b0) begin tests_failed++; $display("FAIL areset_query: got %b expected 0", cache_query); end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         tests_run += 2;
         if (cache_enable !== 1'b0) begin tests_failed++; $display("FAIL areset_cen: got %b expected 0", cache_enable); end
         if (fetch_done !== 1'b0)   begin tests_failed++; $display("FAIL areset_done: got %b expected 0", fetch_done); end
      end
      fetch_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      test_hit(32'h108, 32'h1234_5678);
   endtask

   // Miss completes and a hit request is accepted in the very fetch_done cycle.
   task automatic test_back_to_back();
      logic [31:0] e;
      bit          seen;
      fetch_req = 1'b1; fetch_pc = 32'h600; inst_hit_i = 1'b0; mem_gnt = 1'b1;
      exp_q.push_back(mem_word(32'h600));
      seen = 0;
      for (int j = 0; j < 12 && !seen; j++) begin
         @(negedge clk);
         if (j == 0) fetch_req = 1'b0;
         if (fetch_done === 1'b1) seen = 1;
      end
      tests_run++;
      if (!seen) begin
         tests_failed++; $display("FAIL b2b_timeout: got no fetch_done expected one");
         void'(exp_q.pop_front());
      end else begin
         e = exp_q.pop_front();
         tests_run++;
         if (fetch_inst !== e) begin tests_failed++; $display("FAIL b2b_miss_inst: got %h expected %h", fetch_inst, e); end
         if (cache_enable !== 1'b1) begin tests_failed++; $display("FAIL b2b_cen: got %b expected 1", cache_enable); end
         test_hit(32'h604, 32'hCAFE_0013);
      end
   endtask

   initial begin
      mem[32'h204] = 8'h13; mem[32'h205] = 8'h05; mem[32'h206] = 8'h10; mem[32'h207] = 8'h00;
      mem[32'h300] = 8'h11; mem[32'h301] = 8'h22; mem[32'h302] = 8'h33; mem[32'h303] = 8'h44;
      mem[32'h400] = 8'h93; mem[32'h401] = 8'h80; mem[32'h402] = 8'h70; mem[32'h403] = 8'h06;
      mem[32'h0005_0000] = 8'hB7; mem[32'h0005_0001] = 8'h02;
      mem[32'h0005_0002] = 8'hAB; mem[32'h0005_0003] = 8'hCD;
      mem_din = 8'hEE;

      test_reset();
      test_hit(32'h100, 32'h00A0_0093);
      test_fill("miss", 32'h204, 0);
      test_fill("stall", 32'h204, 2);
      test_fill("uncached", 32'h0005_0000, 0);
      test_flush();
      test_async_reset();
      test_back_to_back();

      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
